// File: rtl/sram_port_arbiter.sv
// Arbitrates one 1-cycle-latency synchronous SRAM between instruction fetch and load/store.
// Optional inst starvation guard is enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
      $error("STARVE_MAX must be in 1..15");
   end

   logic        grant_inst;
   logic        grant_data;
   logic        starve_force;
   logic        resp_valid;
   logic        resp_sel;
   logic [31:0] inst_hold;
   logic [31:0] data_hold;

`ifdef SRAM_ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;

   assign starve_force = inst_req && (starve_cnt == 4'(STARVE_MAX));

   // Counts consecutive denied fetch cycles; a dropped or granted fetch starts over.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= 4'd0;
      end else if (!inst_req || grant_inst) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   assign starve_force = 1'b0;
`endif

   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (!reset) begin
         if (data_req && !starve_force) begin
            grant_data = 1'b1;
         end else if (inst_req) begin
            grant_inst = 1'b1;
         end
      end
   end

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;

   assign sram_en    = grant_inst || grant_data;
   assign sram_addr  = grant_data ? data_addr : inst_addr;
   assign sram_we    = (grant_data && data_wr) ? data_wstrb : 4'd0;
   assign sram_wdata = data_wdata;

   // resp_sel: 0 = inst owns the response, 1 = data owns it.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_sel   <= 1'b0;
      end else begin
         resp_valid <= grant_inst || grant_data;
         resp_sel   <= grant_data;
      end
   end

   // Gated by reset so a response pending across reset assertion is dropped.
   assign inst_data_ok = !reset && resp_valid && !resp_sel;
   assign data_data_ok = !reset && resp_valid && resp_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         inst_hold <= 32'd0;
         data_hold <= 32'd0;
      end else begin
         if (inst_data_ok) inst_hold <= sram_rdata;
         if (data_data_ok) data_hold <= sram_rdata;
      end
   end

   assign inst_rdata = reset ? 32'd0 : (inst_data_ok ? sram_rdata : inst_hold);
   assign data_rdata = reset ? 32'd0 : (data_data_ok ? sram_rdata : data_hold);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: SRAM environment, transaction-level reference model,
// directed test-plan cases and randomized traffic. Honours SRAM_ARB_STARVE_GUARD_EN.
module tb_sram_port_arbiter;

   localparam int unsigned STARVE_MAX = 4;

   logic        clk;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- SRAM environment (read-first, 1-cycle latency) ----------------
   logic [31:0] sram_mem [4096];

   function automatic logic [31:0] init_word(input int i);
      if (i == 0)     return 32'h02800421;
      if (i == 'h401) return 32'h11223344;
      return (32'h9e3779b9 * 32'(i + 1)) ^ 32'(i);
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) sram_mem[i] = init_word(i);
      sram_rdata = 32'd0;
   end

   always @(posedge clk) begin
      if (sram_en) begin
         sram_rdata <= sram_mem[sram_addr[13:2]];
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) sram_mem[sram_addr[13:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
   end

   // ---------------- scoreboard / reference model ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_mem [4096];
   logic [33:0] exp_q [$];   // {is_store, is_data, value}
   logic [31:0] m_hold_i;
   logic [31:0] m_hold_d;
   bit          m_hold_d_known;
   int          m_wait;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check every output against the model, advance the model.
   task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [3:0] ds,
                       input logic [31:0] da, input logic [31:0] dd);
      bit          g_i, g_d, r_i, r_d, r_store;
      logic [31:0] r_val;
      logic [33:0] e;
      @(negedge clk);
      reset = rst; inst_req = ir; inst_addr = ia;
      data_req = dr; data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
      #1;
      g_i = 1'b0; g_d = 1'b0;
      if (!rst) begin
         if (ir && dr) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
            g_i = (m_wait >= int'(STARVE_MAX));
`endif
            g_d = !g_i;
         end else begin
            g_d = dr;
            g_i = ir;
         end
      end
      r_i = 1'b0; r_d = 1'b0; r_store = 1'b0; r_val = 32'd0;
      if (exp_q.size() > 0 && !rst) begin
         e = exp_q[0];
         r_store = e[33]; r_d = e[32]; r_i = !e[32]; r_val = e[31:0];
      end

      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(g_i));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(g_d));
      chk("sram_en", 32'(sram_en), 32'(g_i | g_d));
      chk("sram_we", 32'(sram_we), (g_d && dw) ? 32'(ds) : 32'd0);
      if (g_i) chk("sram_addr_inst", sram_addr, ia);
      if (g_d) chk("sram_addr_data", sram_addr, da);
      if (g_d && dw) chk("sram_wdata", sram_wdata, dd);
      chk("inst_data_ok", 32'(inst_data_ok), 32'(r_i));
      chk("data_data_ok", 32'(data_data_ok), 32'(r_d));
      if (rst) begin
         chk("inst_rdata_rst", inst_rdata, 32'd0);
         chk("data_rdata_rst", data_rdata, 32'd0);
      end else begin
         chk("inst_rdata", inst_rdata, r_i ? r_val : m_hold_i);
         if (r_d && !r_store) chk("data_rdata", data_rdata, r_val);
         else if (!r_d && m_hold_d_known) chk("data_rdata_hold", data_rdata, m_hold_d);
      end

      if (rst) begin
         exp_q.delete();
         m_hold_i = 32'd0; m_hold_d = 32'd0; m_hold_d_known = 1'b1; m_wait = 0;
      end else begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (r_i) m_hold_i = r_val;
         if (r_d) begin
            m_hold_d = r_val;
            m_hold_d_known = !r_store;
         end
         if (!ir || g_i) m_wait = 0;
         else if (m_wait < int'(STARVE_MAX)) m_wait++;
         if (g_i) exp_q.push_back({1'b0, 1'b0, m_mem[ia[13:2]]});
         if (g_d) begin
            exp_q.push_back({dw, 1'b1, m_mem[da[13:2]]});
            if (dw)
               for (int b = 0; b < 4; b++)
                  if (ds[b]) m_mem[da[13:2]][8*b +: 8] = dd[8*b +: 8];
         end
      end
   endtask

   task automatic idle();
      step(0, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'h1c000000 + (32'($urandom_range(0, 1)) << 12) + 32'($urandom_range(0, 7)) * 4;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [5:0] starve_pat;
      reset = 1'b1; inst_req = 1'b0; inst_addr = 32'd0;
      data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
      for (int i = 0; i < 4096; i++) m_mem[i] = init_word(i);
      m_hold_i = 32'd0; m_hold_d = 32'd0; m_hold_d_known = 1'b1; m_wait = 0;

      step(1, 1, 32'h1c000000, 1, 0, 4'd0, 32'h1c001000, 32'd0);
      chk("reset_addr_ok", 32'({inst_addr_ok, data_addr_ok, sram_en}), 32'd0);
      step(1, 0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);

      // Fetch only
      step(0, 1, 32'h1c000000, 0, 0, 4'd0, 32'd0, 32'd0);
      chk("fetch_grant", 32'({inst_addr_ok, sram_we}), 32'h10);
      idle();
      chk("fetch_resp", inst_rdata, 32'h02800421);
      chk("fetch_resp_ok", 32'(inst_data_ok), 32'd1);
      idle();
      chk("fetch_held", inst_rdata, 32'h02800421);

      // Store then load
      step(0, 0, 32'd0, 1, 1, 4'hf, 32'h1c001000, 32'hdeadbeef);
      step(0, 0, 32'd0, 1, 0, 4'h0, 32'h1c001000, 32'd0);
      chk("store_done", 32'(data_data_ok), 32'd1);
      idle();
      chk("load_back", data_rdata, 32'hdeadbeef);

      // Conflict: data first, inst next cycle, responses in grant order
      step(0, 1, 32'h1c000004, 1, 0, 4'h0, 32'h1c001000, 32'd0);
      chk("conflict_grant", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
      step(0, 1, 32'h1c000004, 0, 0, 4'h0, 32'd0, 32'd0);
      chk("conflict_second", 32'({inst_addr_ok, data_data_ok}), 32'b11);
      idle();
      chk("conflict_inst_resp", 32'(inst_data_ok), 32'd1);

      // Starvation: both requests held six cycles
`ifdef SRAM_ARB_STARVE_GUARD_EN
      starve_pat = 6'b010000;
`else
      starve_pat = 6'b000000;
`endif
      for (int k = 0; k < 6; k++) begin
         step(0, 1, 32'h1c000008, 1, 0, 4'h0, 32'h1c000010, 32'd0);
         chk("starve_inst_grant", 32'(inst_addr_ok), 32'(starve_pat[k]));
      end
      idle();

      // Byte store over 0x11223344
      step(0, 0, 32'd0, 1, 1, 4'h2, 32'h1c001004, 32'h0000ab00);
      step(0, 0, 32'd0, 1, 0, 4'h0, 32'h1c001004, 32'd0);
      idle();
      chk("byte_store", data_rdata, 32'h1122ab44);

      // Reset mid-flight
      step(0, 0, 32'd0, 1, 0, 4'h0, 32'h1c001004, 32'd0);
      step(1, 0, 32'd0, 1, 0, 4'h0, 32'h1c001004, 32'd0);
      chk("rst_drop_ok", 32'({data_data_ok, data_addr_ok, sram_en, sram_we}), 32'd0);
      chk("rst_rdata", data_rdata, 32'd0);
      step(0, 0, 32'd0, 1, 0, 4'h0, 32'h1c001004, 32'd0);
      chk("rst_first_grant", 32'(data_addr_ok), 32'd1);
      idle();

      // Randomized traffic with occasional reset
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 75, rand_addr(),
              $urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), rand_addr(), $urandom());
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-ported, 1-cycle-latency synchronous SRAM between the instruction-fetch requester and the load/store requester of the 5-stage pipeline. Grants at most one access per cycle, drives the SRAM port, and routes each response back to its owner one cycle later with an `addr_ok`/`data_ok` handshake. Sits between the core's IF/EX stages and the unified memory, replacing the separate `inst_sram_*` / `data_sram_*` ports.

## Interface
Parameters:
- `STARVE_MAX`, 4, consecutive inst-denied cycles after which inst wins priority (range 1–15)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `inst_req`  in  1  fetch request valid
- `inst_addr`  in  32  fetch address, word-aligned
- `inst_addr_ok`  out  1  fetch request granted this cycle
- `inst_data_ok`  out  1  fetch read data valid
- `inst_rdata`  out  32  fetch read data
- `data_req`  in  1  load/store request valid
- `data_wr`  in  1  1 = store, 0 = load
- `data_wstrb`  in  4  byte enables for stores
- `data_addr`  in  32  load/store address, word-aligned
- `data_wdata`  in  32  store data
- `data_addr_ok`  out  1  load/store request granted this cycle
- `data_data_ok`  out  1  load data valid / store complete
- `data_rdata`  out  32  load data
- `sram_en`  out  1  SRAM access enable
- `sram_we`  out  4  SRAM byte write enables
- `sram_addr`  out  32  SRAM address
- `sram_wdata`  out  32  SRAM write data
- `sram_rdata`  in  32  SRAM read data, valid the cycle after `sram_en`

## Operation
- Grant (combinational, same cycle): only `data_req` → data; only `inst_req` → inst; both → data, unless starvation guard forces inst (see Configuration). No request → no grant, `sram_en`=0.
- Exactly one of `inst_addr_ok`/`data_addr_ok` high when any request present; never both.
- SRAM drive on grant: `sram_en`=1, `sram_addr`=granted address; data store: `sram_we`=`data_wstrb`, `sram_wdata`=`data_wdata`; load or fetch: `sram_we`=0. No grant: `sram_we`=0, `sram_addr`/`sram_wdata` don't-care.
- Response tracker: registers `resp_valid` and `resp_sel` (0 inst, 1 data) at each edge from the current grant.
- Response cycle: `resp_valid` & `resp_sel`=inst → `inst_data_ok`=1, `inst_rdata`=`sram_rdata`; same for data side. Store responses assert `data_data_ok`; `data_rdata` then don't-care.
- Read-data hold: each side captures `sram_rdata` in its own register on its `*_data_ok`; outside `*_data_ok` cycles `*_rdata` shows the last captured value.
- `data_wstrb`=0 store: still granted, SRAM writes nothing, `data_data_ok` next cycle.
- Requester may drop `req` before grant; no state retained for an ungranted request.
- Back-to-back grants allowed every cycle; grants to different sides in consecutive cycles produce responses in grant order.

## Timing
- Grant latency: 0 cycles (`addr_ok` combinational from `req` and arbiter state).
- Response latency: exactly 1 cycle after the grant edge; no backpressure on `data_ok`, requesters must accept.
- Throughput: 1 access/cycle.
- Reset values: `inst_addr_ok`=`data_addr_ok`=0 while `reset` high, `inst_data_ok`=`data_data_ok`=0, `inst_rdata`=`data_rdata`=0, `sram_en`=0, `sram_we`=0, `resp_valid`=0, starvation counter=0.
- Reset mid-operation: a grant in the cycle before `reset` rises produces no `data_ok`; pending response discarded.
- Reset deasserts: first grant possible in the first cycle `reset`=0.

## Configuration
- `SRAM_ARB_STARVE_GUARD_EN` defined: 4-bit counter increments each cycle `inst_req` is high and not granted, saturating at `STARVE_MAX`; clears on inst grant or `inst_req`=0. When counter = `STARVE_MAX` and both request, inst is granted.
- Not defined: strict data priority; no counter; inst may starve indefinitely while `data_req` stays high.

## Test plan
- Fetch only: `inst_req`=1, `inst_addr`=0x1c000000, SRAM word 0x02800421 → `inst_addr_ok`=1 same cycle, `sram_we`=0, next cycle `inst_data_ok`=1, `inst_rdata`=0x02800421; held after.
- Store then load: store 0xdeadbeef, `data_wstrb`=0xf, to 0x1c001000; load same address next cycle → `data_data_ok` on both responses, load `data_rdata`=0xdeadbeef.
- Conflict: both `req` same cycle, data load from 0x1c001000 → data granted, `inst_addr_ok`=0; next cycle inst alone granted; responses in order data then inst.
- Starvation (macro on, `STARVE_MAX`=4): both `req` held high → data granted 4 cycles, inst granted 5th cycle, counter cleared; macro off → data granted every cycle.
- Byte store: `data_wstrb`=0x2, `data_wdata`=0x0000ab00 over word 0x11223344 → read back 0x1122ab44.
- Reset mid-flight: grant load at cycle N, `reset`=1 at N+1 → `data_data_ok`=0 at N+1, all outputs at reset values; first grant accepted cycle after `reset` falls.
